sub_pipe: RTL and testbench

SUB_PIPE -- requirements
Module: sub_pipe

---
 rtl/sub_pipe.sv | 84 ++++++++
 tb/tb_sub_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sub_pipe.sv
// sub_pipe: two-stage signed subtractor with output clamping, valid/ready flow
// control and a saturating count of clamped results delivered downstream.
module sub_pipe #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 15,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IN_W-1:0]  i_data_1,
    input  logic [IN_W-1:0]  i_data_2,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat,
    output logic             o_valid,
    input  logic             i_ready,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_sat_cnt
);
    localparam int MAX_I = 2**(OUT_W-1) - 1;
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'(MAX_I);
    localparam logic signed [IN_W:0] MIN_V = (IN_W+1)'(-MAX_I - 1);

    logic                    s1_v_q, s2_v_q, s2_sat_q;
    logic signed [IN_W:0]    s1_a_q, s1_b_q, diff;
    logic [OUT_W-1:0]        s2_data_q, data_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    sat_d, s2_move, out_xfer, in_xfer;

    always_comb begin
        out_xfer = s2_v_q && i_ready;
        s2_move  = s1_v_q && (!s2_v_q || i_ready);
        o_ready  = !i_rst && (!s1_v_q || s2_move);
        in_xfer  = i_valid && o_ready;
        diff     = s1_a_q - s1_b_q;
        sat_d    = (diff > MAX_V) || (diff < MIN_V);
        data_d   = (diff > MAX_V) ? MAX_V[OUT_W-1:0] :
                   (diff < MIN_V) ? MIN_V[OUT_W-1:0] : diff[OUT_W-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_v_q <= 1'b0;
            s1_a_q <= '0;
            s1_b_q <= '0;
        end else if (in_xfer) begin
            s1_v_q <= 1'b1;
            s1_a_q <= {i_data_1[IN_W-1], i_data_1};
            s1_b_q <= {i_data_2[IN_W-1], i_data_2};
        end else if (s2_move) begin
            s1_v_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_v_q    <= 1'b0;
            s2_sat_q  <= 1'b0;
            s2_data_q <= '0;
        end else if (s2_move) begin
            s2_v_q    <= 1'b1;
            s2_sat_q  <= sat_d;
            s2_data_q <= data_d;
        end else if (out_xfer) begin
            s2_v_q    <= 1'b0;
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_q <= '0;
        else if (i_clr)
            cnt_q <= '0;
        else if (out_xfer && s2_sat_q && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end

    assign o_valid   = s2_v_q;
    assign o_sat     = s2_sat_q;
    assign o_data    = s2_data_q;
    assign o_sat_cnt = cnt_q;
endmodule

// File: tb/tb_sub_pipe.sv
// tb_sub_pipe: table vectors, saturation-counter and reset sequences, and a
// randomized back-pressured stream checked against a queue-based model.
module tb_sub_pipe;
    logic        clk = 1'b0;
    logic        rst, valid, rdy_in, clr;
    logic [13:0] d1, d2;
    logic        r0, r1, r2, sat0, sat1, sat2, val0, val1, val2;
    logic [14:0] dat0;
    logic [13:0] dat1, dat2;
    logic [7:0]  cnt0, cnt1;
    logic [1:0]  cnt2;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    sub_pipe u_def (
        .i_clk(clk), .i_rst(rst), .i_data_1(d1), .i_data_2(d2), .i_valid(valid),
        .o_ready(r0), .o_data(dat0), .o_sat(sat0), .o_valid(val0), .i_ready(rdy_in),
        .i_clr(clr), .o_sat_cnt(cnt0));
    sub_pipe #(.OUT_W(14)) u_o14 (
        .i_clk(clk), .i_rst(rst), .i_data_1(d1), .i_data_2(d2), .i_valid(valid),
        .o_ready(r1), .o_data(dat1), .o_sat(sat1), .o_valid(val1), .i_ready(rdy_in),
        .i_clr(clr), .o_sat_cnt(cnt1));
    sub_pipe #(.OUT_W(14), .CNT_W(2)) u_c2 (
        .i_clk(clk), .i_rst(rst), .i_data_1(d1), .i_data_2(d2), .i_valid(valid),
        .o_ready(r2), .o_data(dat2), .o_sat(sat2), .o_valid(val2), .i_ready(rdy_in),
        .i_clr(clr), .o_sat_cnt(cnt2));

    typedef struct {
        int a, b, d15, s15, d14, s14, cnt;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int clampv(input int d, input int w);
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        return d > mx ? mx : d < mn ? mn : d;
    endfunction

    task automatic send_one(input int a, input int b);
        @(negedge clk);
        d1 = 14'(a); d2 = 14'(b); valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[10];
        int qa[$], qb[$];
        int sent, got, cyc, a, b, e, stale;
        logic hold, pdat_sat;
        logic [14:0] pdat;
        tbl = '{'{100, 37, 63, 0, 63, 0, 0},
                '{8191, -1, 8192, 0, 8191, 1, 1},
                '{-8192, 1, -8193, 0, -8192, 1, 2},
                '{8191, -8192, 16383, 0, 8191, 1, 3},
                '{-8192, 8191, -16383, 0, -8192, 1, 4},
                '{0, 0, 0, 0, 0, 0, 4},
                '{-5, 10, -15, 0, -15, 0, 4},
                '{4000, -4191, 8191, 0, 8191, 0, 4},
                '{-4000, 4192, -8192, 0, -8192, 0, 4},
                '{-1, -8192, 8191, 0, 8191, 0, 4}};
        rst = 1'b1; valid = 1'b0; rdy_in = 1'b1; clr = 1'b0; d1 = '0; d2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(val0), 0);
        chk("rst_data", int'(dat0), 0);
        chk("rst_sat", int'(sat0), 0);
        chk("rst_cnt", int'(cnt1), 0);
        chk("rst_ready", int'(r0), 0);
        rst = 1'b0;
        #1 chk("ready_after_rst", int'(r0), 1);

        foreach (tbl[i]) begin
            send_one(tbl[i].a, tbl[i].b);
            chk($sformatf("v%0d_valid", i), int'(val0), 1);
            chk($sformatf("v%0d_d15", i), int'($signed(dat0)), tbl[i].d15);
            chk($sformatf("v%0d_s15", i), int'(sat0), tbl[i].s15);
            chk($sformatf("v%0d_d14", i), int'($signed(dat1)), tbl[i].d14);
            chk($sformatf("v%0d_s14", i), int'(sat1), tbl[i].s14);
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), int'(val0), 0);
            chk($sformatf("v%0d_cnt8", i), int'(cnt1), tbl[i].cnt);
            chk($sformatf("v%0d_cnt2", i), int'(cnt2), tbl[i].cnt > 3 ? 3 : tbl[i].cnt);
            chk($sformatf("v%0d_cnt_def", i), int'(cnt0), 0);
        end

        send_one(8191, -1);
        @(negedge clk);
        chk("cnt2_hold", int'(cnt2), 3);
        chk("cnt8_five", int'(cnt1), 5);
        send_one(-8192, 1);
        chk("clr_sat_pending", int'(sat2), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_cnt2", int'(cnt2), 0);
        chk("clr_cnt8", int'(cnt1), 0);

        sent = 0; got = 0; cyc = 0; hold = 1'b0; pdat = '0; pdat_sat = 1'b0;
        while (got < 10 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            rdy_in = 1'($urandom % 2);
            valid = (sent < 10) && ($urandom % 4 != 0);
            a = int'($urandom_range(0, 16383)) - 8192;
            b = int'($urandom_range(0, 16383)) - 8192;
            d1 = 14'(a); d2 = 14'(b);
            #1;
            chk("stream_ready", int'(r0), int'(!(qa.size() == 2 && !rdy_in)));
            if (hold) begin
                chk("hold_valid", int'(val0), 1);
                chk("hold_data", int'(dat0), int'(pdat));
                chk("hold_sat", int'(sat0), int'(pdat_sat));
            end
            if (val0 && rdy_in) begin
                if (qa.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    e = qa.pop_front() - qb.pop_front();
                    chk("stream_d15", int'($signed(dat0)), clampv(e, 15));
                    chk("stream_s15", int'(sat0), 0);
                    chk("stream_d14", int'($signed(dat1)), clampv(e, 14));
                    chk("stream_s14", int'(sat1), int'(clampv(e, 14) != e));
                end
                got++;
            end
            if (valid && r0) begin
                qa.push_back(a); qb.push_back(b); sent++;
            end
            hold = val0 && !rdy_in; pdat = dat0; pdat_sat = sat0;
        end
        chk("stream_count", got, 10);

        @(negedge clk);
        rdy_in = 1'b0; valid = 1'b1; d1 = 14'(1); d2 = 14'(2);
        @(negedge clk);
        d1 = 14'(3); d2 = 14'(4);
        @(negedge clk);
        valid = 1'b0;
        chk("full_valid", int'(val0), 1);
        chk("full_ready", int'(r0), 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", int'(val0), 0);
        chk("midrst_data", int'(dat0), 0);
        chk("midrst_ready", int'(r0), 0);
        @(negedge clk);
        rst = 1'b0; rdy_in = 1'b1;
        #1 chk("midrst_ready_after", int'(r0), 1);
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (val0) stale++;
        end
        chk("midrst_stale", stale, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
